sram_rw0_requester: RTL and testbench

- Initiator for the single-port RW0 SRAM macro interface used by the cache data/tag arrays (addr, en, wmode, byte-lane wmask, wdata, rdata valid one cycle after a read).
- Converts a valid/ready request channel into RW0 accesses.
- Tracks the 1-cycle read latency and holds read data under response backpressure.
- Zero-fills the whole array after reset, because macro contents and idle rdata are garbage.
- Sits between cache/test logic and any *_ext array instance.

---
 rtl/sram_rw0_requester_pkg.sv | 17 +
 rtl/sram_rw0_requester_if.sv | 35 +++
 rtl/sram_rsp_hold.sv | 43 ++++
 rtl/sram_rw0_requester.sv | 117 +++++++++++
 tb/tb_sram_rw0_requester.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/sram_rw0_requester_pkg.sv
// Shared types for the RW0 SRAM requester: FSM states and default macro geometry.
package sram_rw0_requester_pkg;

  localparam int DEF_ADDR_W = 9;
  localparam int DEF_DATA_W = 256;
  localparam int DEF_MASK_W = 32;

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_e;

  function automatic state_e reset_state(input bit init_on_reset);
    return init_on_reset ? INIT : RUN;
  endfunction

endpackage

// File: rtl/sram_rw0_requester_if.sv
// Request/response channel plus RW0 macro pins; slave = the requester block, master = client and macro side.
interface sram_rw0_requester_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 256,
  parameter int MASK_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [MASK_W-1:0] req_mask;
  logic [DATA_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_rdata;
  logic              init_done;
  logic [ADDR_W-1:0] RW0_addr;
  logic              RW0_en;
  logic              RW0_wmode;
  logic [MASK_W-1:0] RW0_wmask;
  logic [DATA_W-1:0] RW0_wdata;
  logic [DATA_W-1:0] RW0_rdata;

  modport slave (
    input  req_valid, req_write, req_addr, req_mask, req_wdata, resp_ready, RW0_rdata,
    output req_ready, resp_valid, resp_rdata, init_done,
    output RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );

  modport master (
    output req_valid, req_write, req_addr, req_mask, req_wdata, resp_ready, RW0_rdata,
    input  req_ready, resp_valid, resp_rdata, init_done,
    input  RW0_addr, RW0_en, RW0_wmode, RW0_wmask, RW0_wdata
  );
endinterface

// File: rtl/sram_rsp_hold.sv
// One-entry hold for macro read data: passes the beat through combinationally, parks it when the consumer stalls.
// The parked beat is released on out_rdy_i; hold_vld_o tells the requester to stop issuing.
module sram_rsp_hold #(
  parameter int DATA_W = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_vld_i,
  input  logic [DATA_W-1:0] in_dat_i,
  input  logic              out_rdy_i,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_dat_o,
  output logic              hold_vld_o
);
  logic              hold_vld_q, hold_vld_d;
  logic [DATA_W-1:0] hold_dat_q, hold_dat_d;

  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_dat_d = hold_dat_q;
    // Macro rdata is only valid for one cycle, so a stalled beat must be captured now.
    if (in_vld_i && !out_rdy_i) begin
      hold_vld_d = 1'b1;
      hold_dat_d = in_dat_i;
    end else if (hold_vld_q && out_rdy_i) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      hold_vld_q <= 1'b0;
      hold_dat_q <= '0;
    end else begin
      hold_vld_q <= hold_vld_d;
      hold_dat_q <= hold_dat_d;
    end
  end

  assign out_vld_o  = in_vld_i || hold_vld_q;
  assign out_dat_o  = hold_vld_q ? hold_dat_q : in_dat_i;
  assign hold_vld_o = hold_vld_q;
endmodule

// File: rtl/sram_rw0_requester.sv
// Drives a single-port RW0 SRAM macro from a valid/ready request channel and zero-fills the array after reset.
// Reads respond one cycle after accept; a stalled read beat is parked and blocks new requests until drained.
module sram_rw0_requester
  import sram_rw0_requester_pkg::*;
#(
  parameter int ADDR_W        = DEF_ADDR_W,
  parameter int DATA_W        = DEF_DATA_W,
  parameter int MASK_W        = DEF_MASK_W,
  parameter bit INIT_ON_RESET = 1'b1
) (
  input logic                 clock,
  input logic                 reset_n,
  sram_rw0_requester_if.slave bus
);
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              en;
    logic              wmode;
    logic [MASK_W-1:0] wmask;
    logic [DATA_W-1:0] wdata;
  } rw0_req_t;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] init_cnt_q, init_cnt_d;
  logic              init_done_q, init_done_d;
  logic              rd_pend_q, rd_pend_d;
  logic              hold_vld;
  logic              rsp_vld;
  logic [DATA_W-1:0] rsp_dat;
  logic              req_rdy;
  logic              fire;
  rw0_req_t          rw0;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= reset_state(INIT_ON_RESET);
      init_cnt_q  <= '0;
      init_done_q <= !INIT_ON_RESET;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      init_cnt_q  <= init_cnt_d;
      init_done_q <= init_done_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // A pending beat the consumer refuses this cycle will occupy the hold slot, so stop accepting now.
  assign req_rdy = reset_n && (state_q == RUN) && !hold_vld && !(rd_pend_q && !bus.resp_ready);
  assign fire    = bus.req_valid && req_rdy;

  always_comb begin
    state_d     = state_q;
    init_cnt_d  = init_cnt_q;
    init_done_d = init_done_q;
    rd_pend_d   = 1'b0;
    case (state_q)
      INIT: begin
        init_cnt_d = init_cnt_q + 1'b1;
        if (init_cnt_q == '1) begin
          state_d     = RUN;
          init_done_d = 1'b1;
        end
      end
      RUN: begin
        rd_pend_d = fire && !bus.req_write;
      end
      default: state_d = reset_state(INIT_ON_RESET);
    endcase
  end

  always_comb begin
    rw0 = '0;
    case (state_q)
      INIT: begin
        rw0.addr  = init_cnt_q;
        rw0.en    = 1'b1;
        rw0.wmode = 1'b1;
        rw0.wmask = '1;
      end
      RUN: begin
        rw0.addr  = bus.req_addr;
        rw0.en    = fire;
        rw0.wmode = bus.req_write;
        rw0.wmask = bus.req_mask;
        rw0.wdata = bus.req_wdata;
      end
      default: rw0 = '0;
    endcase
    if (!reset_n) begin
      rw0 = '0;
    end
  end

  sram_rsp_hold #(
    .DATA_W(DATA_W)
  ) u_rsp_hold (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_vld_i  (rd_pend_q),
    .in_dat_i  (bus.RW0_rdata),
    .out_rdy_i (bus.resp_ready),
    .out_vld_o (rsp_vld),
    .out_dat_o (rsp_dat),
    .hold_vld_o(hold_vld)
  );

  assign bus.req_ready  = req_rdy;
  assign bus.resp_valid = reset_n && rsp_vld;
  assign bus.resp_rdata = rsp_dat;
  assign bus.init_done  = init_done_q;
  assign bus.RW0_addr   = rw0.addr;
  assign bus.RW0_en     = rw0.en;
  assign bus.RW0_wmode  = rw0.wmode;
  assign bus.RW0_wmask  = rw0.wmask;
  assign bus.RW0_wdata  = rw0.wdata;
endmodule

// File: tb/tb_sram_rw0_requester.sv
// Bench for sram_rw0_requester with a behavioural RW0 macro whose idle rdata and initial contents are garbage.
module tb_sram_rw0_requester;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 256;
  localparam int MASK_W = 32;
  localparam int DEPTH  = 512;
  localparam int LANE_W = DATA_W / MASK_W;
  localparam logic [DATA_W-1:0] GARBAGE = {8{32'hBADC_0DE5}};
  localparam logic [DATA_W-1:0] PAT_D   = {8{32'hDEAD_BEEF}};
  localparam logic [DATA_W-1:0] PAT_1   = {8{32'h1111_1111}};
  localparam logic [DATA_W-1:0] PAT_2   = {8{32'h2222_2222}};
  localparam logic [DATA_W-1:0] PAT_4   = {8{32'h4444_4444}};
  localparam logic [DATA_W-1:0] ONES    = {DATA_W{1'b1}};

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  sram_rw0_requester_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W)) bus ();

  sram_rw0_requester #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .INIT_ON_RESET(1'b1)
  ) dut (
    .clock  (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural macro: rdata valid only the cycle after a read, garbage otherwise.
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q = GARBAGE;
  logic [DATA_W-1:0] wr_word;
  bit                mem_filled = 1'b0;
  assign bus.RW0_rdata = rdata_q;

  always @(posedge clk) begin
    if (!mem_filled) begin
      for (int i = 0; i < DEPTH; i++) mem[i] = {8{32'hA5A5_0000 | i}};
      mem_filled = 1'b1;
    end
    rdata_q <= GARBAGE;
    if (bus.RW0_en) begin
      if (bus.RW0_wmode) begin
        wr_word = mem[bus.RW0_addr];
        for (int l = 0; l < MASK_W; l++)
          if (bus.RW0_wmask[l]) wr_word[l*LANE_W +: LANE_W] = bus.RW0_wdata[l*LANE_W +: LANE_W];
        mem[bus.RW0_addr] = wr_word;
      end else begin
        rdata_q <= mem[bus.RW0_addr];
      end
    end
  end

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit vld, input bit wr, input logic [ADDR_W-1:0] addr,
                       input logic [MASK_W-1:0] mask, input logic [DATA_W-1:0] wdata, input bit rr);
    bus.req_valid  = vld;
    bus.req_write  = wr;
    bus.req_addr   = addr;
    bus.req_mask   = mask;
    bus.req_wdata  = wdata;
    bus.resp_ready = rr;
  endtask

  // Cycle 0 is the negedge where reset is released; a read is offered throughout to prove it is refused.
  task automatic run_init(input int n, input string name);
    int bad = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      if (c == 0) reset_n = 1'b1;
      drive(1'b1, 1'b0, 9'h055, '0, '0, 1'b1);
      #1;
      if (!(bus.RW0_en === 1'b1 && bus.RW0_wmode === 1'b1 && bus.RW0_addr === ADDR_W'(c) &&
            bus.RW0_wmask === '1 && bus.RW0_wdata === '0 && bus.req_ready === 1'b0 &&
            bus.init_done === 1'b0 && bus.resp_valid === 1'b0)) bad++;
    end
    chk(name, DATA_W'(bad), '0);
  endtask

  typedef struct {
    bit                vld;
    bit                wr;
    logic [ADDR_W-1:0] addr;
    logic [MASK_W-1:0] mask;
    logic [DATA_W-1:0] wdata;
    bit                rr;
    bit                e_rdy;
    bit                e_rv;
    logic [DATA_W-1:0] e_dat;
  } vec_t;

  function automatic vec_t mk(input bit vld, input bit wr, input logic [ADDR_W-1:0] addr,
                              input logic [MASK_W-1:0] mask, input logic [DATA_W-1:0] wdata,
                              input bit rr, input bit e_rdy, input bit e_rv, input logic [DATA_W-1:0] e_dat);
    vec_t v;
    v.vld = vld; v.wr = wr; v.addr = addr; v.mask = mask; v.wdata = wdata;
    v.rr = rr; v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_dat = e_dat;
    return v;
  endfunction

  vec_t vt [15];

  initial begin
    vt[0]  = mk(1, 0, 9'h1A5, '0,   '0,    1, 1, 0, '0);
    vt[1]  = mk(1, 1, 9'd3,   '1,   PAT_D, 1, 1, 1, '0);
    vt[2]  = mk(1, 0, 9'd3,   '0,   '0,    1, 1, 0, '0);
    vt[3]  = mk(1, 1, 9'd7,   32'h0000_0001, ONES, 1, 1, 1, PAT_D);
    vt[4]  = mk(1, 0, 9'd7,   '0,   '0,    1, 1, 0, '0);
    vt[5]  = mk(0, 0, 9'd0,   '0,   '0,    1, 1, 1, 256'hFF);
    vt[6]  = mk(1, 1, 9'd1,   '1,   PAT_1, 1, 1, 0, '0);
    vt[7]  = mk(1, 1, 9'd2,   '1,   PAT_2, 1, 1, 0, '0);
    vt[8]  = mk(1, 1, 9'd4,   '1,   PAT_4, 1, 1, 0, '0);
    vt[9]  = mk(1, 0, 9'd1,   '0,   '0,    1, 1, 0, '0);
    vt[10] = mk(1, 0, 9'd2,   '0,   '0,    1, 1, 1, PAT_1);
    vt[11] = mk(1, 0, 9'd3,   '0,   '0,    1, 1, 1, PAT_2);
    vt[12] = mk(1, 0, 9'd4,   '0,   '0,    1, 1, 1, PAT_D);
    vt[13] = mk(0, 0, 9'd0,   '0,   '0,    1, 1, 1, PAT_4);
    vt[14] = mk(0, 0, 9'd0,   '0,   '0,    1, 1, 0, '0);

    drive(1'b1, 1'b0, 9'h055, '1, ONES, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_req_ready", DATA_W'(bus.req_ready), '0);
    chk("rst_resp_valid", DATA_W'(bus.resp_valid), '0);
    chk("rst_en", DATA_W'(bus.RW0_en), '0);
    chk("rst_wmode", DATA_W'(bus.RW0_wmode), '0);
    chk("rst_wdata", bus.RW0_wdata, '0);
    chk("rst_init_done", DATA_W'(bus.init_done), '0);

    run_init(DEPTH, "init_seq");
    @(negedge clk);
    drive(1'b0, 1'b0, '0, '0, '0, 1'b1);
    #1;
    chk("init_done_at_512", DATA_W'(bus.init_done), 1);
    chk("idle_en", DATA_W'(bus.RW0_en), '0);
    chk("idle_req_ready", DATA_W'(bus.req_ready), 1);

    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      drive(vt[i].vld, vt[i].wr, vt[i].addr, vt[i].mask, vt[i].wdata, vt[i].rr);
      #1;
      chk($sformatf("vec%0d_req_ready", i), DATA_W'(bus.req_ready), DATA_W'(vt[i].e_rdy));
      chk($sformatf("vec%0d_en", i), DATA_W'(bus.RW0_en), DATA_W'(vt[i].vld && vt[i].e_rdy));
      chk($sformatf("vec%0d_resp_valid", i), DATA_W'(bus.resp_valid), DATA_W'(vt[i].e_rv));
      if (vt[i].e_rv) chk($sformatf("vec%0d_rdata", i), bus.resp_rdata, vt[i].e_dat);
      if (vt[i].vld) chk($sformatf("vec%0d_addr", i), DATA_W'(bus.RW0_addr), DATA_W'(vt[i].addr));
    end

    // Read under backpressure: beat is parked, a competing write is refused until drain.
    @(negedge clk); drive(1'b1, 1'b0, 9'd3, '0, '0, 1'b0); #1;
    chk("bp_s0_req_ready", DATA_W'(bus.req_ready), 1);
    chk("bp_s0_en", DATA_W'(bus.RW0_en), 1);
    @(negedge clk); drive(1'b1, 1'b1, 9'd9, '1, PAT_1, 1'b0); #1;
    chk("bp_s1_req_ready", DATA_W'(bus.req_ready), '0);
    chk("bp_s1_en", DATA_W'(bus.RW0_en), '0);
    chk("bp_s1_resp_valid", DATA_W'(bus.resp_valid), 1);
    chk("bp_s1_rdata", bus.resp_rdata, PAT_D);
    @(negedge clk); #1;
    chk("bp_s2_req_ready", DATA_W'(bus.req_ready), '0);
    chk("bp_s2_resp_valid", DATA_W'(bus.resp_valid), 1);
    chk("bp_s2_rdata", bus.resp_rdata, PAT_D);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0, 1'b0); #1;
    chk("bp_s3_resp_valid", DATA_W'(bus.resp_valid), 1);
    chk("bp_s3_rdata", bus.resp_rdata, PAT_D);
    @(negedge clk); drive(1'b1, 1'b1, 9'd9, '1, PAT_1, 1'b1); #1;
    chk("bp_s4_req_ready", DATA_W'(bus.req_ready), '0);
    chk("bp_s4_en", DATA_W'(bus.RW0_en), '0);
    chk("bp_s4_resp_valid", DATA_W'(bus.resp_valid), 1);
    chk("bp_s4_rdata", bus.resp_rdata, PAT_D);
    @(negedge clk); drive(1'b1, 1'b0, 9'd9, '0, '0, 1'b1); #1;
    chk("bp_s5_resp_valid", DATA_W'(bus.resp_valid), '0);
    chk("bp_s5_req_ready", DATA_W'(bus.req_ready), 1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0, 1'b1); #1;
    chk("bp_refused_write_rdata", bus.resp_rdata, '0);
    chk("bp_refused_write_valid", DATA_W'(bus.resp_valid), 1);

    // Reset with a parked beat, then reset again mid-init at init_cnt=100.
    @(negedge clk); drive(1'b1, 1'b0, 9'd1, '0, '0, 1'b0); #1;
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0, 1'b0); #1;
    chk("r6_pending_valid", DATA_W'(bus.resp_valid), 1);
    @(negedge clk); reset_n = 1'b0; #1;
    chk("r6_rst_resp_valid", DATA_W'(bus.resp_valid), '0);
    chk("r6_rst_en", DATA_W'(bus.RW0_en), '0);
    chk("r6_rst_req_ready", DATA_W'(bus.req_ready), '0);
    run_init(100, "init_partial");
    @(negedge clk); reset_n = 1'b0; #1;
    chk("r6_mid_init_en", DATA_W'(bus.RW0_en), '0);
    chk("r6_mid_init_addr", DATA_W'(bus.RW0_addr), '0);
    chk("r6_mid_init_wmask", DATA_W'(bus.RW0_wmask), '0);
    chk("r6_mid_init_done", DATA_W'(bus.init_done), '0);
    run_init(DEPTH, "init_restart");
    @(negedge clk); drive(1'b1, 1'b0, 9'd3, '0, '0, 1'b1); #1;
    chk("r6_done_after_restart", DATA_W'(bus.init_done), 1);
    chk("r6_read_ready", DATA_W'(bus.req_ready), 1);
    @(negedge clk); drive(1'b0, 1'b0, '0, '0, '0, 1'b1); #1;
    chk("r6_refill_valid", DATA_W'(bus.resp_valid), 1);
    chk("r6_refill_rdata", bus.resp_rdata, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end
endmodule
